ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline. Consumes the ID_EX register outputs and
//  forwards operands from EX/MEM and MEM/WB. Computes the ALU result, resolves BEQ, and
//  runs a 32-cycle iterative multiplier. Drives the EX/MEM pipeline register.
// PARAMETERS
//  XLEN      32   datapath width
//  MUL_CYC   32   shift-add iterations per MULT, one bit per cycle
// PORTS
//  clk                    in   1     rising-edge clock
//  rst                    in   1     asynchronous reset, active-high
//  rs1_ID_EX,rs2_ID_EX,rd_ID_EX in 5 source/dest register numbers
//  funct_ID_EX            in   6     R-type funct
//  word_ID_EX             in   32    sign-extended immediate
//  read_data1_ID_EX/2     in   32    register-file operands
//  PC_ID_EX               in   32    address of the instruction in EX
//  ALUOp_ID_EX            in   2     00 add, 01 sub, 10 use funct
//  ALUSrc/Mem_Read/Mem_Write/PcSrc/Mem_to_Reg/Reg_Write/RegDst_ID_EX in 1 control bits
//  Reg_Write_MEM_WB       in   1     MEM/WB write enable, for forwarding
//  write_reg_MEM_WB       in   5     MEM/WB destination register
//  write_data_WB          in   32    WB-stage result
//  ALU_result_EX_MEM      out  32    registered ALU/MULT result
//  store_data_EX_MEM      out  32    registered forwarded rs2 value
//  write_reg_EX_MEM       out  5     registered destination: RegDst ? rd : rs2
//  Mem_Read/Mem_Write/Mem_to_Reg/Reg_Write_EX_MEM out 1 registered control bits
//  ovf_EX_MEM             out  1     registered signed-overflow flag
//  branch_taken           out  1     comb: PcSrc_ID_EX && operands equal && !stall
//  branch_target          out  32    comb: PC_ID_EX + 4 + (word_ID_EX << 2)
//  stall                  out  1     comb: hold PC, IF_ID and ID_EX this cycle
// BEHAVIOUR
//  - Reset: every registered output is 0; FSM goes to IDLE; mult counter is 0.
//    A reset during BUSY aborts the multiply. No result is written.
//  - Forwarding for rs1, checked in priority order:
//    1. Reg_Write_EX_MEM && write_reg_EX_MEM != 0 && write_reg_EX_MEM == rs1 -> ALU_result_EX_MEM
//    2. MEM/WB match under the same conditions -> write_data_WB
//    3. otherwise -> read_data1
//    rs2 uses the same rules. ALU B input = ALUSrc ? word : forwarded rs2.
//  - ALU, with ALUOp=10, decodes funct:
//    20 add, 22 sub, 24 and, 25 or, 2A slt (signed), 18 MULT (low 32 bits of the product).
//    Any other funct gives result 0 with the control bits passed through. All arithmetic is mod 2^32.
//  - Single-cycle instructions have 1-cycle latency: the EX/MEM register loads every edge when stall=0.
//  - MULT FSM:
//    - IDLE: MULT present -> stall=1, latch the forwarded operands, counter=0 -> BUSY.
//    - BUSY: stall=1; one shift-add bit per cycle; counter reaches MUL_CYC-1 -> DONE.
//    - DONE: stall=0; EX/MEM captures the product at this edge -> IDLE.
//    - stall is high for MUL_CYC+1 cycles. The product enters EX/MEM MUL_CYC+2 edges after
//      the MULT reaches EX.
//  - While stall=1, EX/MEM loads a bubble (all control bits 0, data 0).
//    ID_EX is held by its owner. The latched mult operands ignore later forwarding changes.
//  - A MULT back-to-back with a MULT re-enters IDLE->BUSY on the cycle after DONE.
//  - Register 0 is never a forwarding source, and a write_reg of 0 has no effect downstream.
// CONFIGURATION
//  EX_OVF_TRAP_EN defined:
//    - add/sub (ALUOp 00/01 or funct 20/22) with signed overflow sets ovf_EX_MEM=1.
//    - It also forces Reg_Write_EX_MEM=0 and Mem_Read/Mem_Write_EX_MEM=0 for that instruction.
//  EX_OVF_TRAP_EN undefined: ovf_EX_MEM is held at 0 and overflow wraps silently.
// TESTING
//  1. rst=1 mid-MULT, at BUSY count 10 -> all outputs 0 and stall=0 the same cycle; the MULT result never appears.
//  2. add: rs1=1 (100), rs2=2 (200), rd=3, RegDst=1 -> next edge ALU_result_EX_MEM=300,
//     write_reg_EX_MEM=3, Reg_Write_EX_MEM=1.
//  3. add r3 followed by sub r4,r3,r1, stale read_data1=0 -> EX/MEM forwarding gives 300-100=200.
//     With the MEM/WB path only, write_data_WB=7 -> 7-100.
//  4. beq, PC=0x00400008, word=4, operands 100/100 -> branch_taken=1 and
//     branch_target=0x0040001C. Operands 100/101 -> branch_taken=0.
//  5. MULT 0xFFFF x 0x10001 -> stall high for 33 cycles, bubbles in EX/MEM, then
//     ALU_result_EX_MEM=0xFFFFFFFF.
//  6. With EX_OVF_TRAP_EN: add 0x7FFFFFFF + 1 -> ovf_EX_MEM=1 and Reg_Write_EX_MEM=0.
//     Without it: result 0x80000000 and ovf_EX_MEM=0.

Source files
------------

// File: rtl/ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage MIPS pipeline. Forwards rs1/rs2
//                from EX/MEM and MEM/WB, computes the ALU result, resolves
//                BEQ, and runs an iterative shift-add multiplier that stalls
//                the front of the pipe while busy. Drives the EX/MEM register.
//                Optional feature macro: EX_OVF_TRAP_EN (signed-overflow trap
//                on add/sub; squashes register and memory writes).
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN    = 32,
    parameter int MUL_CYC = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_ID_EX,
    input  logic [4:0]      rs2_ID_EX,
    input  logic [4:0]      rd_ID_EX,
    input  logic [5:0]      funct_ID_EX,
    input  logic [XLEN-1:0] word_ID_EX,
    input  logic [XLEN-1:0] read_data1_ID_EX,
    input  logic [XLEN-1:0] read_data2_ID_EX,
    input  logic [XLEN-1:0] PC_ID_EX,
    input  logic [1:0]      ALUOp_ID_EX,
    input  logic            ALUSrc_ID_EX,
    input  logic            Mem_Read_ID_EX,
    input  logic            Mem_Write_ID_EX,
    input  logic            PcSrc_ID_EX,
    input  logic            Mem_to_Reg_ID_EX,
    input  logic            Reg_Write_ID_EX,
    input  logic            RegDst_ID_EX,
    input  logic            Reg_Write_MEM_WB,
    input  logic [4:0]      write_reg_MEM_WB,
    input  logic [XLEN-1:0] write_data_WB,
    output logic [XLEN-1:0] ALU_result_EX_MEM,
    output logic [XLEN-1:0] store_data_EX_MEM,
    output logic [4:0]      write_reg_EX_MEM,
    output logic            Mem_Read_EX_MEM,
    output logic            Mem_Write_EX_MEM,
    output logic            Mem_to_Reg_EX_MEM,
    output logic            Reg_Write_EX_MEM,
    output logic            ovf_EX_MEM,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            stall
);

    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_MULT = 6'h18;
    localparam int         c_CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_stall;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [XLEN-1:0]     r_prod;
    logic [XLEN-1:0]     w_fwd_a;
    logic [XLEN-1:0]     w_fwd_b;
    logic [XLEN-1:0]     w_alu_b;
    logic [XLEN-1:0]     w_sum;
    logic [XLEN-1:0]     w_diff;
    logic [XLEN-1:0]     w_alu_res;
    logic                w_is_mult;
    logic                w_trap;

    // Operand forwarding: EX/MEM beats MEM/WB; register 0 never forwards.
    always_comb begin
        w_fwd_a = read_data1_ID_EX;
        w_fwd_b = read_data2_ID_EX;
        if (Reg_Write_MEM_WB && write_reg_MEM_WB != 5'd0 && write_reg_MEM_WB == rs1_ID_EX)
            w_fwd_a = write_data_WB;
        if (Reg_Write_EX_MEM && write_reg_EX_MEM != 5'd0 && write_reg_EX_MEM == rs1_ID_EX)
            w_fwd_a = ALU_result_EX_MEM;
        if (Reg_Write_MEM_WB && write_reg_MEM_WB != 5'd0 && write_reg_MEM_WB == rs2_ID_EX)
            w_fwd_b = write_data_WB;
        if (Reg_Write_EX_MEM && write_reg_EX_MEM != 5'd0 && write_reg_EX_MEM == rs2_ID_EX)
            w_fwd_b = ALU_result_EX_MEM;
    end

    assign w_alu_b   = ALUSrc_ID_EX ? word_ID_EX : w_fwd_b;
    assign w_sum     = w_fwd_a + w_alu_b;
    assign w_diff    = w_fwd_a - w_alu_b;
    assign w_is_mult = (ALUOp_ID_EX == 2'b10) && (funct_ID_EX == c_FN_MULT);

    // ALU result select; MULT reads the finished product from the multiplier.
    always_comb begin
        w_alu_res = '0;
        case (ALUOp_ID_EX)
            2'b00: w_alu_res = w_sum;
            2'b01: w_alu_res = w_diff;
            2'b10: begin
                case (funct_ID_EX)
                    c_FN_ADD:  w_alu_res = w_sum;
                    c_FN_SUB:  w_alu_res = w_diff;
                    c_FN_AND:  w_alu_res = w_fwd_a & w_alu_b;
                    c_FN_OR:   w_alu_res = w_fwd_a | w_alu_b;
                    c_FN_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_alu_b))};
                    c_FN_MULT: w_alu_res = r_prod;
                    default:   w_alu_res = '0;
                endcase
            end
            default: w_alu_res = '0;
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    logic w_is_add;
    logic w_is_sub;
    assign w_is_add = (ALUOp_ID_EX == 2'b00) || ((ALUOp_ID_EX == 2'b10) && (funct_ID_EX == c_FN_ADD));
    assign w_is_sub = (ALUOp_ID_EX == 2'b01) || ((ALUOp_ID_EX == 2'b10) && (funct_ID_EX == c_FN_SUB));
    // Signed overflow: operands' signs agree (add) or differ (sub) and the result sign flips.
    assign w_trap = (w_is_add && (w_fwd_a[XLEN-1] == w_alu_b[XLEN-1]) && (w_sum[XLEN-1]  != w_fwd_a[XLEN-1]))
                 || (w_is_sub && (w_fwd_a[XLEN-1] != w_alu_b[XLEN-1]) && (w_diff[XLEN-1] != w_fwd_a[XLEN-1]));
`else
    assign w_trap = 1'b0;
`endif

    // Branch resolves on the forwarded register operands, suppressed while stalled.
    assign branch_taken  = PcSrc_ID_EX && (w_fwd_a == w_fwd_b) && !stall;
    assign branch_target = PC_ID_EX + XLEN'(4) + {word_ID_EX[XLEN-3:0], 2'b00};
    assign stall         = w_stall && !rst;

    // Multiplier FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Multiplier FSM next state and stall; DONE releases the stall for the capture edge.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mult) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift-add datapath: operands are latched once in IDLE so later forwarding changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_is_mult) begin
                r_mcand  <= w_fwd_a;
                r_mplier <= w_fwd_b;
                r_prod   <= '0;
                r_cnt    <= '0;
            end
        end else if (r_state == S_BUSY) begin
            if (r_mplier[0]) r_prod <= r_prod + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    // EX/MEM pipeline register; a bubble is inserted on every stalled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_stall) begin
            ALU_result_EX_MEM <= '0;
            store_data_EX_MEM <= '0;
            write_reg_EX_MEM  <= '0;
            Mem_Read_EX_MEM   <= 1'b0;
            Mem_Write_EX_MEM  <= 1'b0;
            Mem_to_Reg_EX_MEM <= 1'b0;
            Reg_Write_EX_MEM  <= 1'b0;
            ovf_EX_MEM        <= 1'b0;
        end else begin
            ALU_result_EX_MEM <= w_alu_res;
            store_data_EX_MEM <= w_fwd_b;
            write_reg_EX_MEM  <= RegDst_ID_EX ? rd_ID_EX : rs2_ID_EX;
            Mem_Read_EX_MEM   <= Mem_Read_ID_EX  && !w_trap;
            Mem_Write_EX_MEM  <= Mem_Write_ID_EX && !w_trap;
            Mem_to_Reg_EX_MEM <= Mem_to_Reg_ID_EX;
            Reg_Write_EX_MEM  <= Reg_Write_ID_EX && !w_trap;
            ovf_EX_MEM        <= w_trap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage: cycle-level reference
//                model plus directed vectors with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_stage;
    localparam int XLEN    = 32;
    localparam int MUL_CYC = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_ID_EX = '0, rs2_ID_EX = '0, rd_ID_EX = '0;
    logic [5:0]  funct_ID_EX = '0;
    logic [31:0] word_ID_EX = '0, read_data1_ID_EX = '0, read_data2_ID_EX = '0, PC_ID_EX = '0;
    logic [1:0]  ALUOp_ID_EX = '0;
    logic        ALUSrc_ID_EX = 0, Mem_Read_ID_EX = 0, Mem_Write_ID_EX = 0, PcSrc_ID_EX = 0;
    logic        Mem_to_Reg_ID_EX = 0, Reg_Write_ID_EX = 0, RegDst_ID_EX = 0;
    logic        Reg_Write_MEM_WB = 0;
    logic [4:0]  write_reg_MEM_WB = '0;
    logic [31:0] write_data_WB = '0;
    logic [31:0] ALU_result_EX_MEM, store_data_EX_MEM, branch_target;
    logic [4:0]  write_reg_EX_MEM;
    logic        Mem_Read_EX_MEM, Mem_Write_EX_MEM, Mem_to_Reg_EX_MEM, Reg_Write_EX_MEM;
    logic        ovf_EX_MEM, branch_taken, stall;

    ex_stage #(.XLEN(XLEN), .MUL_CYC(MUL_CYC)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
        .funct_ID_EX(funct_ID_EX), .word_ID_EX(word_ID_EX),
        .read_data1_ID_EX(read_data1_ID_EX), .read_data2_ID_EX(read_data2_ID_EX),
        .PC_ID_EX(PC_ID_EX), .ALUOp_ID_EX(ALUOp_ID_EX), .ALUSrc_ID_EX(ALUSrc_ID_EX),
        .Mem_Read_ID_EX(Mem_Read_ID_EX), .Mem_Write_ID_EX(Mem_Write_ID_EX),
        .PcSrc_ID_EX(PcSrc_ID_EX), .Mem_to_Reg_ID_EX(Mem_to_Reg_ID_EX),
        .Reg_Write_ID_EX(Reg_Write_ID_EX), .RegDst_ID_EX(RegDst_ID_EX),
        .Reg_Write_MEM_WB(Reg_Write_MEM_WB), .write_reg_MEM_WB(write_reg_MEM_WB),
        .write_data_WB(write_data_WB),
        .ALU_result_EX_MEM(ALU_result_EX_MEM), .store_data_EX_MEM(store_data_EX_MEM),
        .write_reg_EX_MEM(write_reg_EX_MEM), .Mem_Read_EX_MEM(Mem_Read_EX_MEM),
        .Mem_Write_EX_MEM(Mem_Write_EX_MEM), .Mem_to_Reg_EX_MEM(Mem_to_Reg_EX_MEM),
        .Reg_Write_EX_MEM(Reg_Write_EX_MEM), .ovf_EX_MEM(ovf_EX_MEM),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_res = '0, m_sd = '0, m_prod = '0;
    logic [4:0]  m_wr = '0;
    logic        m_mr = 0, m_mw = 0, m_mtr = 0, m_rw = 0, m_ovf = 0;
    int          mcnt = 0;   // 0: no multiply; 1..MUL_CYC: busy; MUL_CYC+1: product ready

    typedef struct packed {
        logic [31:0] res, sd, a, b, bta;
        logic [4:0]  wr;
        logic        mr, mw, mtr, rw, ovf, stall, bt;
    } exp_t;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (m_rw && m_wr != 0 && m_wr == r) return m_res;
        if (Reg_Write_MEM_WB && write_reg_MEM_WB != 0 && write_reg_MEM_WB == r) return write_data_WB;
        return rf;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [31:0] bop;
        logic mult;
        e    = '0;
        e.a  = fwd(rs1_ID_EX, read_data1_ID_EX);
        e.b  = fwd(rs2_ID_EX, read_data2_ID_EX);
        bop  = ALUSrc_ID_EX ? word_ID_EX : e.b;
        mult = (ALUOp_ID_EX == 2'd2) && (funct_ID_EX == 6'h18);
        e.stall = !rst && mult && (mcnt <= MUL_CYC);
        e.bt    = PcSrc_ID_EX && (e.a == e.b) && !e.stall;
        e.bta   = PC_ID_EX + 32'd4 + word_ID_EX * 32'd4;
        if (!e.stall) begin
            case (ALUOp_ID_EX)
                2'd0: e.res = e.a + bop;
                2'd1: e.res = e.a - bop;
                2'd2: case (funct_ID_EX)
                          6'h20: e.res = e.a + bop;
                          6'h22: e.res = e.a - bop;
                          6'h24: e.res = e.a & bop;
                          6'h25: e.res = e.a | bop;
                          6'h2A: e.res = ($signed(e.a) < $signed(bop)) ? 32'd1 : 32'd0;
                          6'h18: e.res = m_prod;
                          default: e.res = 32'd0;
                      endcase
                default: e.res = 32'd0;
            endcase
            e.sd  = e.b;
            e.wr  = RegDst_ID_EX ? rd_ID_EX : rs2_ID_EX;
            e.mr  = Mem_Read_ID_EX;
            e.mw  = Mem_Write_ID_EX;
            e.mtr = Mem_to_Reg_ID_EX;
            e.rw  = Reg_Write_ID_EX;
`ifdef EX_OVF_TRAP_EN
            begin
                longint s;
                logic addop, subop;
                addop = (ALUOp_ID_EX == 2'd0) || (ALUOp_ID_EX == 2'd2 && funct_ID_EX == 6'h20);
                subop = (ALUOp_ID_EX == 2'd1) || (ALUOp_ID_EX == 2'd2 && funct_ID_EX == 6'h22);
                s = addop ? longint'($signed(e.a)) + longint'($signed(bop))
                          : longint'($signed(e.a)) - longint'($signed(bop));
                if ((addop || subop) && (s > 64'sd2147483647 || s < -64'sd2147483648)) begin
                    e.ovf = 1'b1; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
                end
            end
`endif
        end
        return e;
    endfunction

    exp_t cur;
    always_comb cur = model();

    // Model state advances on the clock; reset clears it immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_res <= '0; m_sd <= '0; m_wr <= '0; m_mr <= 0; m_mw <= 0;
            m_mtr <= 0; m_rw <= 0; m_ovf <= 0; mcnt <= 0; m_prod <= '0;
        end else begin
            m_res <= cur.res; m_sd <= cur.sd; m_wr <= cur.wr; m_mr <= cur.mr;
            m_mw <= cur.mw; m_mtr <= cur.mtr; m_rw <= cur.rw; m_ovf <= cur.ovf;
            if (mcnt == 0) begin
                if (cur.stall) begin
                    mcnt   <= 1;
                    m_prod <= cur.a * cur.b;
                end
            end else if (mcnt <= MUL_CYC) mcnt <= mcnt + 1;
            else mcnt <= 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_alu_result",    ALU_result_EX_MEM, m_res);
        chk("cmp_store_data",    store_data_EX_MEM, m_sd);
        chk("cmp_write_reg",     32'(write_reg_EX_MEM), 32'(m_wr));
        chk1("cmp_mem_read",     Mem_Read_EX_MEM, m_mr);
        chk1("cmp_mem_write",    Mem_Write_EX_MEM, m_mw);
        chk1("cmp_mem_to_reg",   Mem_to_Reg_EX_MEM, m_mtr);
        chk1("cmp_reg_write",    Reg_Write_EX_MEM, m_rw);
        chk1("cmp_ovf",          ovf_EX_MEM, m_ovf);
        chk1("cmp_stall",        stall, cur.stall);
        chk1("cmp_branch_taken", branch_taken, cur.bt);
        chk("cmp_branch_target", branch_target, cur.bta);
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        rs1_ID_EX = 0; rs2_ID_EX = 0; rd_ID_EX = 0; funct_ID_EX = 0; word_ID_EX = 0;
        read_data1_ID_EX = 0; read_data2_ID_EX = 0; PC_ID_EX = 0; ALUOp_ID_EX = 0;
        ALUSrc_ID_EX = 0; Mem_Read_ID_EX = 0; Mem_Write_ID_EX = 0; PcSrc_ID_EX = 0;
        Mem_to_Reg_ID_EX = 0; Reg_Write_ID_EX = 0; RegDst_ID_EX = 0;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] v1, input logic [31:0] v2);
        nop();
        ALUOp_ID_EX = 2'd2; funct_ID_EX = fn; rs1_ID_EX = s1; rs2_ID_EX = s2; rd_ID_EX = d;
        read_data1_ID_EX = v1; read_data2_ID_EX = v2; RegDst_ID_EX = 1; Reg_Write_ID_EX = 1;
    endtask

    // Counts stalled cycles of a multiply, bounded; returns count (limit means it never ended).
    task automatic wait_mult(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n == 10) begin
                chk1("mult_bubble_rw", Reg_Write_EX_MEM, 1'b0);
                chk("mult_bubble_res", ALU_result_EX_MEM, 32'd0);
                #1;
                Reg_Write_MEM_WB = 1; write_reg_MEM_WB = 5'd13; write_data_WB = 32'd2;
            end
        end
    endtask

    logic [5:0]  t_fn  [5] = '{6'h24, 6'h25, 6'h2A, 6'h2A, 6'h27};
    logic [31:0] t_v1  [5] = '{32'h0000F0F0, 32'h0000F0F0, 32'hFFFFFFFF, 32'd1, 32'd5};
    logic [31:0] t_v2  [5] = '{32'h0000FF00, 32'h0000FF00, 32'd1, 32'hFFFFFFFF, 32'd6};
    logic [31:0] t_exp [5] = '{32'h0000F000, 32'h0000FFF0, 32'd1, 32'd0, 32'd0};

    initial begin
        int n;
        bit seen;
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_alu_result", ALU_result_EX_MEM, 32'd0);
        chk1("reset_reg_write", Reg_Write_EX_MEM, 1'b0);
        chk1("reset_stall", stall, 1'b0);
        rst = 0;

        // add r3 = r1 + r2
        rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'd100, 32'd200);
        nxt();
        chk("add_result", ALU_result_EX_MEM, 32'd300);
        chk("add_write_reg", 32'(write_reg_EX_MEM), 32'd3);
        chk1("add_reg_write", Reg_Write_EX_MEM, 1'b1);

        // sub r4 = r3 - r1: EX/MEM wins over a matching MEM/WB
        rtype(6'h22, 5'd3, 5'd1, 5'd4, 32'd0, 32'd100);
        Reg_Write_MEM_WB = 1; write_reg_MEM_WB = 5'd3; write_data_WB = 32'd7;
        nxt();
        chk("fwd_exmem_sub", ALU_result_EX_MEM, 32'd200);
        rtype(6'h22, 5'd3, 5'd1, 5'd4, 32'd0, 32'd100);
        nxt();
        chk("fwd_memwb_sub", ALU_result_EX_MEM, 32'hFFFFFFA3);

        // register 0 never forwards
        Reg_Write_MEM_WB = 0;
        rtype(6'h20, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6);
        nxt();
        rtype(6'h20, 5'd0, 5'd2, 5'd7, 32'd40, 32'd1);
        Reg_Write_MEM_WB = 1; write_reg_MEM_WB = 5'd0; write_data_WB = 32'd999;
        nxt();
        chk("r0_no_forward", ALU_result_EX_MEM, 32'd41);
        Reg_Write_MEM_WB = 0;

        // beq
        nop();
        PcSrc_ID_EX = 1; ALUOp_ID_EX = 2'd1; rs1_ID_EX = 5'd5; rs2_ID_EX = 5'd6;
        read_data1_ID_EX = 32'd100; read_data2_ID_EX = 32'd100;
        PC_ID_EX = 32'h00400008; word_ID_EX = 32'd4;
        @(negedge clk);
        chk1("beq_taken", branch_taken, 1'b1);
        chk("beq_target", branch_target, 32'h0040001C);
        #1;
        read_data2_ID_EX = 32'd101;
        #1;
        chk1("beq_not_taken", branch_taken, 1'b0);
        nxt();

        // logic / slt / unknown funct
        for (int i = 0; i < 5; i++) begin
            rtype(t_fn[i], 5'd10, 5'd11, 5'd12, t_v1[i], t_v2[i]);
            nxt();
            chk($sformatf("alu_table_%0d", i), ALU_result_EX_MEM, t_exp[i]);
        end
        chk1("unknown_funct_rw_passes", Reg_Write_EX_MEM, 1'b1);

        // lw: base + offset, destination is rs2
        nop();
        ALUSrc_ID_EX = 1; rs1_ID_EX = 5'd10; rs2_ID_EX = 5'd9;
        read_data1_ID_EX = 32'h1000; read_data2_ID_EX = 32'hABCD; word_ID_EX = 32'd8;
        Mem_Read_ID_EX = 1; Mem_to_Reg_ID_EX = 1; Reg_Write_ID_EX = 1;
        nxt();
        chk("lw_addr", ALU_result_EX_MEM, 32'h1008);
        chk("lw_write_reg", 32'(write_reg_EX_MEM), 32'd9);
        chk1("lw_mem_read", Mem_Read_EX_MEM, 1'b1);
        chk("lw_store_data", store_data_EX_MEM, 32'hABCD);

        // signed overflow on add
        rtype(6'h20, 5'd10, 5'd11, 5'd12, 32'h7FFFFFFF, 32'd1);
        nxt();
        chk("ovf_add_result", ALU_result_EX_MEM, 32'h80000000);
`ifdef EX_OVF_TRAP_EN
        chk1("ovf_flag", ovf_EX_MEM, 1'b1);
        chk1("ovf_reg_write", Reg_Write_EX_MEM, 1'b0);
`else
        chk1("ovf_flag", ovf_EX_MEM, 1'b0);
        chk1("ovf_reg_write", Reg_Write_EX_MEM, 1'b1);
`endif

        // MULT 0xFFFF x 0x10001
        rtype(6'h18, 5'd13, 5'd14, 5'd15, 32'h0000FFFF, 32'h00010001);
        wait_mult(n);
        chk("mult_stall_cycles", n, MUL_CYC + 1);
        nxt();
        chk("mult_result", ALU_result_EX_MEM, 32'hFFFFFFFF);
        chk("mult_write_reg", 32'(write_reg_EX_MEM), 32'd15);

        // back-to-back MULT, rs1 forwarded from the previous product
        Reg_Write_MEM_WB = 0;
        rtype(6'h18, 5'd15, 5'd17, 5'd18, 32'd0, 32'd3);
        wait_mult(n);
        chk("mult2_stall_cycles", n, MUL_CYC + 1);
        nxt();
        chk("mult2_result", ALU_result_EX_MEM, 32'hFFFFFFFD);

        // reset during BUSY at count 10 aborts the multiply
        Reg_Write_MEM_WB = 0;
        rtype(6'h18, 5'd13, 5'd14, 5'd15, 32'h0000FFFF, 32'h00010001);
        repeat (12) @(negedge clk);
        #1;
        rst = 1;
        nop();
        #1;
        chk("abort_alu_result", ALU_result_EX_MEM, 32'd0);
        chk("abort_write_reg", 32'(write_reg_EX_MEM), 32'd0);
        chk1("abort_reg_write", Reg_Write_EX_MEM, 1'b0);
        chk1("abort_stall", stall, 1'b0);
        nxt();
        rst = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ALU_result_EX_MEM == 32'hFFFFFFFF) seen = 1;
        end
        chk1("abort_no_result", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
